// File: rtl/day3_edge_detector.sv
// Per-lane level-to-strobe edge detector: compares each input bit with its
// registered previous sample and emits one-cycle rising/falling strobes.
module day3_edge_detector #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] rising_edge_o,
  output logic [WIDTH-1:0] falling_edge_o
);

  logic [WIDTH-1:0] a_q;
  logic             primed;
  logic             detect_en;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      primed <= 1'b0;
    end else begin
      a_q    <= a_i;
      primed <= 1'b1;
    end
  end

  // Gating with primed hides the reset value of a_q until a real sample exists.
  assign detect_en      = primed & ~reset;
  assign rising_edge_o  =  a_i & ~a_q & {WIDTH{detect_en}};
  assign falling_edge_o = ~a_i &  a_q & {WIDTH{detect_en}};

endmodule

// File: tb/tb_day3_edge_detector.sv
// Scoreboard bench for day3_edge_detector: directed test-plan sequences with
// constant expectations, then random stimulus against a prev-sample model.
module tb_day3_edge_detector;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] rising_edge_o;
  logic [W-1:0] falling_edge_o;

  typedef struct {
    string        tag;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] m_prev = '0;
  logic         m_primed = 1'b0;

  day3_edge_detector #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .a_i            (a_i),
    .rising_edge_o  (rising_edge_o),
    .falling_edge_o (falling_edge_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle just after the edge, queue its expectation, compare mid-cycle.
  task automatic step(input string tag, input logic rst, input logic [W-1:0] a,
                      input logic [W-1:0] er, input logic [W-1:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    a_i   = a;
    e.tag = tag; e.rise = er; e.fall = ef;
    sb_q.push_back(e);
    if (rst) begin
      m_prev   = '0;
      m_primed = 1'b0;
    end else begin
      m_prev   = a;
      m_primed = 1'b1;
    end
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_rise"}, 32'(rising_edge_o), 32'(e.rise));
      check({e.tag, "_fall"}, 32'(falling_edge_o), 32'(e.fall));
      check({e.tag, "_excl"}, 32'(rising_edge_o & falling_edge_o), 32'd0);
    end
  endtask

  // Replicates a single-lane directed pattern across all lanes.
  task automatic step1(input string tag, input logic rst, input logic a,
                       input logic er, input logic ef);
    step(tag, rst, {W{a}}, {W{er}}, {W{ef}});
  endtask

  initial begin
    logic [W-1:0] a, er, ef;
    logic [5:0] tog_a, tog_r, tog_f;

    #1;
    check("reset_init_rise", 32'(rising_edge_o), 32'd0);
    check("reset_init_fall", 32'(falling_edge_o), 32'd0);

    // Reset with a_i=1, then released with a_i=1 for 3 cycles: no strobes.
    step1("rst_hold",  1'b1, 1'b1, 1'b0, 1'b0);
    step1("rst_rel0",  1'b0, 1'b1, 1'b0, 1'b0);
    step1("rst_rel1",  1'b0, 1'b1, 1'b0, 1'b0);
    step1("rst_rel2",  1'b0, 1'b1, 1'b0, 1'b0);

    // Falling edge from steady 1, then prime at 0.
    step1("fall0",     1'b0, 1'b0, 1'b0, 1'b1);
    step1("fall1",     1'b0, 1'b0, 1'b0, 1'b0);

    // Single rising edge held 4 cycles.
    step1("rise0",     1'b0, 1'b1, 1'b1, 1'b0);
    step1("rise1",     1'b0, 1'b1, 1'b0, 1'b0);
    step1("rise2",     1'b0, 1'b1, 1'b0, 1'b0);
    step1("rise3",     1'b0, 1'b1, 1'b0, 1'b0);

    // Falling edge again, leaving the detector primed at 0.
    step1("fallb0",    1'b0, 1'b0, 1'b0, 1'b1);
    step1("fallb1",    1'b0, 1'b0, 1'b0, 1'b0);

    // Toggle pattern 0,1,0,1,1,0 (index 0 driven first).
    tog_a = 6'b011010; tog_r = 6'b001010; tog_f = 6'b100100;
    for (int i = 0; i < 6; i++)
      step1($sformatf("toggle%0d", i), 1'b0, tog_a[i], tog_r[i], tog_f[i]);

    // Reset asserted in the same cycle a_i goes 0->1.
    step1("midrst0",   1'b1, 1'b1, 1'b0, 1'b0);
    step1("midrst1",   1'b0, 1'b1, 1'b0, 1'b0);
    step1("midrst2",   1'b0, 1'b1, 1'b0, 1'b0);
    step1("midrst3",   1'b0, 1'b0, 1'b0, 1'b1);

    // Per-lane independence: lanes change in opposite directions.
    step("lanes0", 1'b0, 4'b0101, 4'b0101, 4'b0000);
    step("lanes1", 1'b0, 4'b1010, 4'b1010, 4'b0101);

    // Random per-lane stimulus against the prev-sample model, occasional reset.
    for (int i = 0; i < 48; i++) begin
      logic rst;
      rst = ($urandom_range(0, 15) == 0);
      a   = W'($urandom);
      er  = (rst || !m_primed) ? '0 : ( a & ~m_prev);
      ef  = (rst || !m_primed) ? '0 : (~a &  m_prev);
      step($sformatf("rand%0d", i), rst, a, er, ef);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
